// File: rtl/exp_stream_ctrl.sv
// Valid/ready and credit wrapper around the non-stallable exp pipeline.
// A token line marks which core slots carry real arguments; results land in a show-ahead FIFO.
module exp_stream_ctrl #(
  parameter int ARG_W   = 20,
  parameter int RES_W   = 32,
  parameter int EXP_LAT = 32,
  parameter int DEPTH   = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ARG_W-1:0] in_data,
  output logic [ARG_W-1:0] exp_arg,
  input  logic [RES_W-1:0] exp_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RES_W-1:0] out_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(EXP_LAT + 2) + 1;
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [EXP_LAT:0] r_tok;
  logic [RES_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_infl;

  logic             w_acc;
  logic             w_push;
  logic             w_pop;
  logic [SW-1:0]    w_credit_used;

  // The core samples every edge; only the token line says which samples are real.
  assign exp_arg = in_data;

  // Credits come from registered state only, so a pop frees its slot one cycle later.
  assign w_credit_used = SW'(r_count) + SW'(r_infl);
  assign in_ready      = ~reset & (w_credit_used < SW'(DEPTH));
  assign w_acc         = in_valid & in_ready;

  assign w_push    = r_tok[EXP_LAT];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tok <= '0;
    end else begin
      r_tok <= {r_tok[EXP_LAT-1:0], w_acc};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_infl <= '0;
    end else begin
      case ({w_acc, w_push})
        2'b10:   r_infl <= r_infl + IW'(1);
        2'b01:   r_infl <= r_infl - IW'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push && !reset) r_mem[r_wr_ptr] <= exp_res;
  end

endmodule

// File: tb/tb_exp_stream_ctrl.sv
// Bench for exp_stream_ctrl: a stand-in exp core plus a queue model of accepted arguments
// checked every cycle, with directed tests pinning latency, values, backpressure and reset.
module tb_exp_stream_ctrl;
  localparam int ARG_W   = 20;
  localparam int RES_W   = 32;
  localparam int EXP_LAT = 32;
  localparam int DEPTH   = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ARG_W-1:0] in_data = '0;
  logic [ARG_W-1:0] exp_arg;
  logic [RES_W-1:0] exp_res;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [RES_W-1:0] out_data;

  always #5 clk = ~clk;

  exp_stream_ctrl #(.ARG_W(ARG_W), .RES_W(RES_W), .EXP_LAT(EXP_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .exp_arg(exp_arg), .exp_res(exp_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Q4.16 argument -> Q16.16 result, truncated.
  function automatic logic [RES_W-1:0] exp_ref(input logic [ARG_W-1:0] a);
    int  s;
    real x;
    s = $signed(a);
    x = $itor(s) / 65536.0;
    return RES_W'($rtoi($exp(x) * 65536.0));
  endfunction

  // Stand-in core: samples ix every edge, result valid EXP_LAT edges later.
  logic [RES_W-1:0] core_pipe [EXP_LAT+1];
  initial for (int k = 0; k <= EXP_LAT; k++) core_pipe[k] = '0;
  always @(posedge clk) begin
    core_pipe[0] <= exp_ref(exp_arg);
    for (int k = 1; k <= EXP_LAT; k++) core_pipe[k] <= core_pipe[k-1];
  end
  assign exp_res = core_pipe[EXP_LAT];

  typedef struct {
    logic [RES_W-1:0] val;
    int               avail;
  } ent_t;

  ent_t mq[$];
  int   outstanding = 0;
  int   cyc = 0;
  bit   chk_en = 0;
  int   checks = 0;
  int   errors = 0;
  int   dut_acc = 0;
  int   dut_pop = 0;
  bit   e_rdy;
  bit   e_val;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, expv);
    end
  endtask

  // Per-cycle compare against the queue model; state updates describe the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_rdy = !reset && (outstanding < DEPTH);
        e_val = (mq.size() > 0) && (mq[0].avail <= cyc);
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("out_valid", 32'(out_valid), 32'(e_val));
        if (e_val) chk("out_data", out_data, mq[0].val);
        chk("exp_arg", 32'(exp_arg), 32'(in_data));
        checks++;
        if (dut.r_tok[EXP_LAT] && (32'(dut.r_count) == DEPTH)) begin
          errors++;
          $display("FAIL wr_full cyc=%0d actual=write_at_full required=no_write", cyc);
        end
        if (in_valid && in_ready) dut_acc++;
        if (out_valid && out_ready) dut_pop++;
        if (reset) begin
          mq.delete();
          outstanding = 0;
        end else begin
          if (e_val && out_ready) begin
            void'(mq.pop_front());
            outstanding--;
          end
          if (in_valid && e_rdy) begin
            mq.push_back('{val: exp_ref(in_data), avail: cyc + EXP_LAT + 2});
            outstanding++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string nm, output int c, output logic [RES_W-1:0] d);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_valid && k < 200);
    c = cyc;
    d = out_data;
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL %s actual=timeout required=out_valid", nm);
    end
  endtask

  int               a0, c0, c1, streak, acc_s, pop_s, low_cnt;
  logic [RES_W-1:0] d0, d1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    step();
    chk_en = 1;
    step();
    reset = 1'b0;

    // Pin the reference itself.
    chk("ref_1p0", exp_ref(20'h10000), 32'h0002B7E1);
    chk("ref_0p0", exp_ref(20'h00000), 32'h00010000);
    chk("ref_m1p0", exp_ref(20'hF0000), 32'h00005E2D);

    // Single argument: latency EXP_LAT+2 from the accept cycle, one-cycle valid.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 20'h10000;
    a0 = cyc;
    step();
    in_valid = 1'b0;
    wait_out("single", c0, d0);
    chk("single_lat", 32'(c0 - a0), 32'd34);
    chk("single_val", d0, 32'h0002B7E1);
    @(negedge clk);
    chk("single_once", 32'(out_valid), 32'd0);

    // Zero then -1.0 back to back.
    step();
    in_valid = 1'b1;
    in_data  = 20'h00000;
    step();
    in_data  = 20'hF0000;
    step();
    in_valid = 1'b0;
    wait_out("pair", c0, d0);
    chk("pair_first", d0, 32'h00010000);
    @(negedge clk);
    chk("pair_second_v", 32'(out_valid), 32'd1);
    chk("pair_second_d", out_data, 32'h00005E2D);

    // Streaming 200 arguments at full rate.
    step();
    acc_s = dut_acc;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          in_valid = 1'b1;
          in_data  = ARG_W'($urandom);
          step();
        end
        in_valid = 1'b0;
      end
      begin
        wait_out("stream", c1, d1);
        streak = 1;
        repeat (199) begin
          @(negedge clk);
          if (out_valid) streak++;
        end
      end
    join
    chk("stream_acc", 32'(dut_acc - acc_s), 32'd200);
    chk("stream_streak", 32'(streak), 32'd200);
    repeat (10) step();

    // Backpressure: exactly DEPTH accepts, then one pop frees one credit.
    out_ready = 1'b0;
    acc_s = dut_acc;
    in_valid = 1'b1;
    in_data  = 20'h08000;
    repeat (120) step();
    chk("bp_acc", 32'(dut_acc - acc_s), 32'd64);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    chk("bp_count", 32'(dut.r_count), 32'd64);
    pop_s = dut_pop;
    acc_s = dut_acc;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    repeat (40) step();
    chk("bp_one_pop", 32'(dut_pop - pop_s), 32'd1);
    chk("bp_one_acc", 32'(dut_acc - acc_s), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (100) step();

    // Random valid/ready for 5000 cycles, then drain.
    acc_s = dut_acc;
    pop_s = dut_pop;
    for (int i = 0; i < 5000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = ARG_W'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (120) step();
    chk("rand_balance", 32'(dut_pop - pop_s), 32'(dut_acc - acc_s));
    chk("rand_empty", 32'(out_valid), 32'd0);

    // Reset mid-flight discards everything; a fresh argument still returns once.
    acc_s = dut_acc;
    in_valid = 1'b1;
    in_data  = 20'h04000;
    repeat (10) step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_acc", 32'(dut_acc - acc_s), 32'd10);
    low_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (!out_valid) low_cnt++;
    end
    chk("rst_quiet", 32'(low_cnt), 32'd40);
    step();
    pop_s = dut_pop;
    in_valid = 1'b1;
    in_data  = 20'h10000;
    a0 = cyc;
    step();
    in_valid = 1'b0;
    wait_out("rst_fresh", c0, d0);
    chk("rst_fresh_lat", 32'(c0 - a0), 32'd34);
    chk("rst_fresh_val", d0, 32'h0002B7E1);
    repeat (30) step();
    chk("rst_fresh_once", 32'(dut_pop - pop_s), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
